// File: rtl/multi_cycle_control_unit_if.sv
// multi_cycle_control_unit_if: datapath-to-control bundle (opcode/flags in, control strobes out)
interface multi_cycle_control_unit_if;
  logic [5:0] op_instruction;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       bus_error;
  logic       instr_done;
  logic [3:0] state;
  modport master (
    input  op_instruction, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, bus_error, instr_done, state
  );
  modport slave (
    output op_instruction, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, bus_error, instr_done, state
  );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: multi-cycle MIPS sequencing FSM with memory-ready timeout
module multi_cycle_control_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  multi_cycle_control_unit_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADR = 4'd2, MEM_RD = 4'd3,
                         MEM_WB = 4'd4, MEM_WR = 4'd5, EXECUTE = 4'd6, ALU_WB = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010;
  logic [3:0] state, nxt;
  logic [7:0] cnt;
  logic [5:0] op;
  logic       ready, wait_st, timeout, legal;
  assign op      = bus.op_instruction;
  assign ready   = bus.mem_ready;
  assign wait_st = state == FETCH || state == MEM_RD || state == MEM_WR;
  // a ready arriving on the timeout cycle still completes normally
  assign timeout = wait_st && !ready && cnt == 8'(TIMEOUT);
  assign legal   = op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = ready ? DECODE : FETCH;
      DECODE:  nxt = op == OP_R ? EXECUTE : (op == OP_LW || op == OP_SW) ? MEM_ADR :
                     op == OP_BEQ ? BRANCH : op == OP_J ? JUMP : FETCH;
      MEM_ADR: nxt = op == OP_SW ? MEM_WR : MEM_RD;
      MEM_RD:  nxt = ready ? MEM_WB : timeout ? FETCH : MEM_RD;
      MEM_WR:  nxt = (ready || timeout) ? FETCH : MEM_WR;
      EXECUTE: nxt = ALU_WB;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (wait_st && !ready && !timeout) ? cnt + 8'd1 : '0;
    end
  assign bus.pc_write      = (state == FETCH && ready) || state == JUMP;
  assign bus.pc_write_cond = state == BRANCH;
  assign bus.i_or_d        = state == MEM_RD || state == MEM_WR;
  assign bus.mem_read      = state == FETCH || state == MEM_RD;
  assign bus.mem_write     = state == MEM_WR;
  assign bus.ir_write      = state == FETCH && ready;
  assign bus.mem_to_reg    = state == MEM_WB;
  assign bus.reg_dst       = state == ALU_WB;
  assign bus.reg_write     = state == MEM_WB || state == ALU_WB;
  assign bus.alu_src_a     = state == MEM_ADR || state == EXECUTE || state == BRANCH;
  assign bus.alu_src_b     = state == FETCH ? 2'b01 : state == DECODE ? 2'b11 :
                             state == MEM_ADR ? 2'b10 : 2'b00;
  assign bus.alu_op        = state == EXECUTE ? 2'b10 : state == BRANCH ? 2'b01 : 2'b00;
  assign bus.pc_source     = state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
  assign bus.illegal_op    = state == DECODE && !legal;
  assign bus.bus_error     = timeout;
  assign bus.instr_done    = state == MEM_WB || state == ALU_WB || state == BRANCH ||
                             state == JUMP || (state == MEM_WR && ready);
  assign bus.state         = state;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: directed-vector check of the multi-cycle control FSM
module tb_multi_cycle_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  multi_cycle_control_unit_if bus ();
  multi_cycle_control_unit #(.TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic mr);
    @(posedge clk);
    #2 bus.mem_ready = mr;
    #1;
  endtask
  initial begin
    bus.op_instruction = 6'b000000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #12;
    check("rst_state", bus.state, 0);
    check("rst_mem_read", bus.mem_read, 1);
    check("rst_alu_src_b", bus.alu_src_b, 2'b01);
    check("rst_pc_write", bus.pc_write, 0);
    check("rst_ir_write", bus.ir_write, 0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("r_fetch_state", bus.state, 0);
    check("r_fetch_ir_write", bus.ir_write, 1);
    check("r_fetch_pc_write", bus.pc_write, 1);
    cyc(1);
    check("r_decode", bus.state, 1);
    check("r_decode_srcb", bus.alu_src_b, 2'b11);
    cyc(1);
    check("r_exec", bus.state, 6);
    check("r_exec_aluop", bus.alu_op, 2'b10);
    check("r_exec_srca", bus.alu_src_a, 1);
    cyc(1);
    check("r_wb", bus.state, 7);
    check("r_wb_reg_write", bus.reg_write, 1);
    check("r_wb_reg_dst", bus.reg_dst, 1);
    check("r_wb_done", bus.instr_done, 1);
    bus.op_instruction = 6'b100011;
    cyc(1);
    check("r_back_fetch", bus.state, 0);
    check("r_done_clear", bus.instr_done, 0);
    cyc(1);
    check("lw_decode", bus.state, 1);
    cyc(1);
    check("lw_adr", bus.state, 2);
    check("lw_adr_srcb", bus.alu_src_b, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(0);
      check("lw_rd_wait", bus.state, 3);
      check("lw_rd_iord", bus.i_or_d, 1);
      check("lw_rd_memread", bus.mem_read, 1);
    end
    cyc(1);
    check("lw_rd_ready", bus.state, 3);
    cyc(1);
    check("lw_wb", bus.state, 4);
    check("lw_wb_reg_write", bus.reg_write, 1);
    check("lw_wb_mem_to_reg", bus.mem_to_reg, 1);
    check("lw_wb_done", bus.instr_done, 1);
    bus.op_instruction = 6'b101011;
    cyc(1);
    check("lw_back_fetch", bus.state, 0);
    cyc(1);
    check("sw_decode", bus.state, 1);
    cyc(1);
    check("sw_adr", bus.state, 2);
    cyc(1);
    check("sw_wr", bus.state, 5);
    check("sw_wr_mem_write", bus.mem_write, 1);
    check("sw_wr_mem_read", bus.mem_read, 0);
    check("sw_wr_done", bus.instr_done, 1);
    bus.op_instruction = 6'b000100;
    cyc(1);
    check("sw_back_fetch", bus.state, 0);
    cyc(1);
    check("beq_decode", bus.state, 1);
    cyc(1);
    check("beq_branch", bus.state, 8);
    check("beq_pwc", bus.pc_write_cond, 1);
    check("beq_pw", bus.pc_write, 0);
    check("beq_aluop", bus.alu_op, 2'b01);
    check("beq_pcsrc", bus.pc_source, 2'b01);
    check("beq_done", bus.instr_done, 1);
    bus.op_instruction = 6'b000010;
    cyc(1);
    check("beq_back_fetch", bus.state, 0);
    cyc(1);
    check("j_decode", bus.state, 1);
    cyc(1);
    check("j_jump", bus.state, 9);
    check("j_pw", bus.pc_write, 1);
    check("j_pwc", bus.pc_write_cond, 0);
    check("j_pcsrc", bus.pc_source, 2'b10);
    bus.op_instruction = 6'b111111;
    cyc(1);
    check("j_back_fetch", bus.state, 0);
    cyc(1);
    check("ill_decode", bus.state, 1);
    check("ill_pulse", bus.illegal_op, 1);
    check("ill_reg_write", bus.reg_write, 0);
    check("ill_mem_write", bus.mem_write, 0);
    check("ill_pc_write", bus.pc_write, 0);
    cyc(0);
    check("ill_back_fetch", bus.state, 0);
    check("ill_clear", bus.illegal_op, 0);
    for (int i = 2; i <= 15; i++) begin
      cyc(0);
      check("to_wait_state", bus.state, 0);
      check("to_wait_berr", bus.bus_error, 0);
      check("to_wait_irw", bus.ir_write, 0);
    end
    cyc(0);
    check("to_berr", bus.bus_error, 1);
    check("to_berr_memread", bus.mem_read, 1);
    check("to_berr_irw", bus.ir_write, 0);
    check("to_berr_pcw", bus.pc_write, 0);
    cyc(0);
    check("to_restart_state", bus.state, 0);
    check("to_restart_berr", bus.bus_error, 0);
    for (int i = 2; i <= 15; i++) cyc(0);
    check("to2_pre_berr", bus.bus_error, 0);
    bus.op_instruction = 6'b101011;
    cyc(1);
    check("to2_ready_berr", bus.bus_error, 0);
    check("to2_ready_irw", bus.ir_write, 1);
    cyc(1);
    check("to2_decode", bus.state, 1);
    cyc(1);
    check("rst_sw_adr", bus.state, 2);
    cyc(0);
    check("rst_sw_wr", bus.state, 5);
    check("rst_sw_wr_done", bus.instr_done, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_state", bus.state, 0);
    check("rst_mid_mem_write", bus.mem_write, 0);
    check("rst_mid_reg_write", bus.reg_write, 0);
    check("rst_mid_pc_write", bus.pc_write, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_state", bus.state, 0);
    check("rel_mem_read", bus.mem_read, 1);
    check("rel_alu_src_b", bus.alu_src_b, 2'b01);
    check("rel_mem_write", bus.mem_write, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
Sequencing FSM for the multi-cycle MIPS datapath. It steps a single shared memory port, ALU and register file through FETCH/DECODE/EXECUTE/MEM/WB phases for R-type, LW, SW, BEQ and J.
Memory accesses use a ready handshake with a bounded wait timeout. Unknown opcodes are flagged and the unit returns to fetch.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready in any memory state before aborting (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; one clock, no other clocks
op_instruction  input  6  opcode field of the instruction register (IR[31:26])
zero  input  1  ALU zero flag
mem_ready  input  1  memory completed current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero (branch)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  regfile write data: 0=ALUOut, 1=MDR
reg_dst  output  1  write register: 0=rt, 1=rd
reg_write  output  1  regfile write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct field
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse on unknown opcode
bus_error  output  1  one-cycle pulse on memory timeout
instr_done  output  1  one-cycle pulse when an instruction retires
state  output  4  current state code (debug)

Behaviour:
- State register and wait counter are reset asynchronously; on reset: state=FETCH, wait counter=0, all outputs 0 except those FETCH drives combinationally (mem_read=1, alu_src_b=01).
- Reset asserted mid-instruction: abort immediately, no pc_write/reg_write/mem_write in the following cycle.
- State codes: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9. Codes 10–15 are unreachable; if entered, go to FETCH.
- Outputs are decoded combinationally from the state. Handshake-qualified outputs also depend on mem_ready. Unlisted outputs are 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - On mem_ready go to DECODE; else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - otherwise illegal_op=1 this cycle, go to FETCH, no writes.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready set instr_done=1 and go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next is ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1. Next is FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1. Next is FETCH.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in one of those states with mem_ready=0.
  - When it equals TIMEOUT with mem_ready still 0: bus_error=1 for that cycle, request outputs still driven, next state FETCH. No ir_write/pc_write/reg_write/instr_done.
  - mem_ready=1 in the same cycle as the timeout takes priority: normal completion, no bus_error.
- Latency with mem_ready always 1 (cycles from FETCH entry to return to FETCH): R=4, LW=5, SW=4, BEQ=3, J=3.
- pc_write and pc_write_cond are never both 1. mem_read and mem_write are never both 1.

Test Plan:
- Reset mid-MEM_WR (assert reset 3ns after the clock) -> state=0 immediately; mem_write=0; mem_read=1, alu_src_b=01 after release.
- mem_ready=1 constant, op=000000 -> states 0,1,6,7,0. In state 7: reg_write=1, reg_dst=1, alu_op visible as 10 in state 6, instr_done pulse.
- op=100011 with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles. MEM_WB then asserts reg_write=1, mem_to_reg=1. Total 8 cycles.
- op=000100 then op=000010 -> BRANCH: pc_write_cond=1, alu_op=01, pc_source=01. JUMP: pc_write=1, pc_source=10. Each 3 cycles.
- op=111111 -> DECODE pulses illegal_op=1, state returns to 0, no reg_write/mem_write/pc_write.
- TIMEOUT=15, mem_ready held 0 in FETCH -> bus_error pulse on the 16th FETCH cycle, ir_write never asserted. Repeat with mem_ready=1 on that cycle -> DECODE, no bus_error.
